queue_buf_param: RTL and testbench



---
 rtl/queue_buf_param_if.sv | 38 +++
 rtl/queue_buf_param.sv | 100 ++++++++++
 tb/tb_queue_buf_param.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/queue_buf_param_if.sv
// queue_buf_param_if: request/data/status bundle for queue_buf_param.
// Carries o_peak_count only when QUEUE_STATS_EN is defined.
interface queue_buf_param_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
);
    logic                   i_clear;
    logic                   i_mode;
    logic                   i_enque;
    logic [DATA_WIDTH-1:0]  i_data_in;
    logic                   i_deque;
    logic [DATA_WIDTH-1:0]  o_data_out;
    logic                   o_data_valid;
    logic                   o_full;
    logic                   o_empty;
    logic                   o_almost_full;
    logic                   o_almost_empty;
    logic [ADDRESS_WIDTH:0] o_count;
    logic                   o_overflow;
    logic                   o_underflow;
    logic                   o_error;
`ifdef QUEUE_STATS_EN
    logic [ADDRESS_WIDTH:0] o_peak_count;
    modport master(output i_clear, i_mode, i_enque, i_data_in, i_deque,
                   input o_data_out, o_data_valid, o_full, o_empty, o_almost_full,
                   o_almost_empty, o_count, o_overflow, o_underflow, o_error, o_peak_count);
    modport slave(input i_clear, i_mode, i_enque, i_data_in, i_deque,
                  output o_data_out, o_data_valid, o_full, o_empty, o_almost_full,
                  o_almost_empty, o_count, o_overflow, o_underflow, o_error, o_peak_count);
`else
    modport master(output i_clear, i_mode, i_enque, i_data_in, i_deque,
                   input o_data_out, o_data_valid, o_full, o_empty, o_almost_full,
                   o_almost_empty, o_count, o_overflow, o_underflow, o_error);
    modport slave(input i_clear, i_mode, i_enque, i_data_in, i_deque,
                  output o_data_out, o_data_valid, o_full, o_empty, o_almost_full,
                  o_almost_empty, o_count, o_overflow, o_underflow, o_error);
`endif
endinterface

// File: rtl/queue_buf_param.sv
// queue_buf_param: circular-buffer queue with run-time FIFO/LIFO ordering and sticky error flags.
// Define QUEUE_STATS_EN to add the o_peak_count high-water mark.
module queue_buf_param #(
    parameter int DATA_WIDTH       = 8,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int DEPTH            = 1 << ADDRESS_WIDTH,
    parameter int ALMOST_FULL_LVL  = DEPTH - 2,
    parameter int ALMOST_EMPTY_LVL = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    queue_buf_param_if.slave  bus
);
    localparam int CW = ADDRESS_WIDTH + 1;
    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] L_AF    = CW'(ALMOST_FULL_LVL);
    localparam logic [CW-1:0] L_AE    = CW'(ALMOST_EMPTY_LVL);

    logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]            r_count;
    logic                     r_mode;
    logic [DATA_WIDTH-1:0]    r_data_out;
    logic                     r_valid, r_error, r_overflow, r_underflow;

    logic                     w_empty, w_full, w_rd_ok, w_wr_ok, w_replace;
    logic [ADDRESS_WIDTH-1:0] w_top, w_rd_addr, w_wr_addr;
    logic [CW-1:0]            w_count_next;

    // A full buffer can still take a write when a read retires an entry in the same cycle.
    always_comb begin
        w_empty      = r_count == '0;
        w_full       = r_count == L_DEPTH;
        w_rd_ok      = bus.i_deque & ~w_empty;
        w_wr_ok      = bus.i_enque & (~w_full | w_rd_ok);
        w_replace    = r_mode & w_rd_ok & w_wr_ok;
        w_top        = r_wr_ptr - ADDRESS_WIDTH'(1);
        w_rd_addr    = r_mode ? w_top : r_rd_ptr;
        w_wr_addr    = w_replace ? w_top : r_wr_ptr;
        w_count_next = bus.i_clear ? '0 : r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_mode      <= 1'b0;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.i_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_empty) r_mode <= bus.i_mode;
            // LIFO: push and pop cancel on the write pointer, giving replace-top.
            r_wr_ptr    <= r_wr_ptr + ADDRESS_WIDTH'(w_wr_ok) - ADDRESS_WIDTH'(r_mode & w_rd_ok);
            r_rd_ptr    <= r_rd_ptr + ADDRESS_WIDTH'(~r_mode & w_rd_ok);
            r_count     <= w_count_next;
            if (w_rd_ok) r_data_out <= r_mem[w_rd_addr];
            r_valid     <= w_rd_ok;
            r_error     <= (bus.i_enque & ~w_wr_ok) | (bus.i_deque & w_empty);
            r_overflow  <= r_overflow | (bus.i_enque & ~w_wr_ok);
            r_underflow <= r_underflow | (bus.i_deque & w_empty);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_ok & ~bus.i_clear) r_mem[w_wr_addr] <= bus.i_data_in;
    end

`ifdef QUEUE_STATS_EN
    logic [CW-1:0] r_peak;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_peak <= '0;
        else if (bus.i_clear) r_peak <= '0;
        else if (w_count_next > r_peak) r_peak <= w_count_next;
    end
    assign bus.o_peak_count = r_peak;
`endif

    assign bus.o_data_out     = r_data_out;
    assign bus.o_data_valid   = r_valid;
    assign bus.o_full         = w_full;
    assign bus.o_empty        = w_empty;
    assign bus.o_almost_full  = r_count >= L_AF;
    assign bus.o_almost_empty = r_count <= L_AE;
    assign bus.o_count        = r_count;
    assign bus.o_overflow     = r_overflow;
    assign bus.o_underflow    = r_underflow;
    assign bus.o_error        = r_error;
endmodule

// File: tb/tb_queue_buf_param.sv
// tb_queue_buf_param: vector table, directed corner sequences and random traffic
// checked against a queue-based reference model.
module tb_queue_buf_param;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    queue_buf_param_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4)) bus();
    queue_buf_param dut(.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    bit         m_mode;
    logic [7:0] m_dout;
    bit         m_valid, m_err, m_ovf, m_unf;
    int         m_peak;

    typedef struct {
        bit clr, mode, enq, deq;
        logic [7:0] din;
        bit v;
        logic [7:0] dout;
        int cnt;
        bit err;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode = 0; m_dout = 0; m_valid = 0; m_err = 0; m_ovf = 0; m_unf = 0; m_peak = 0;
    endtask

    task automatic model(input bit clr, mode, enq, deq, input logic [7:0] din);
        bit was_empty;
        m_valid = 0;
        m_err = 0;
        if (clr) begin
            mq.delete();
            m_ovf = 0; m_unf = 0; m_peak = 0;
            return;
        end
        was_empty = mq.size() == 0;
        if (enq && deq && !was_empty) begin
            m_valid = 1;
            if (m_mode) begin
                m_dout = mq[$];
                mq[$] = din;
            end else begin
                m_dout = mq.pop_front();
                mq.push_back(din);
            end
        end else begin
            if (deq) begin
                if (was_empty) begin m_unf = 1; m_err = 1; end
                else begin
                    m_valid = 1;
                    m_dout = m_mode ? mq.pop_back() : mq.pop_front();
                end
            end
            if (enq) begin
                if (mq.size() == DEPTH) begin m_ovf = 1; m_err = 1; end
                else mq.push_back(din);
            end
        end
        if (was_empty) m_mode = mode;
        if (mq.size() > m_peak) m_peak = mq.size();
    endtask

    task automatic compare_all(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".data_out"}, 32'(bus.o_data_out), 32'(m_dout));
        chk({tag, ".valid"}, 32'(bus.o_data_valid), 32'(m_valid));
        chk({tag, ".count"}, 32'(bus.o_count), 32'(n));
        chk({tag, ".full"}, 32'(bus.o_full), 32'(n == DEPTH));
        chk({tag, ".empty"}, 32'(bus.o_empty), 32'(n == 0));
        chk({tag, ".afull"}, 32'(bus.o_almost_full), 32'(n >= DEPTH - 2));
        chk({tag, ".aempty"}, 32'(bus.o_almost_empty), 32'(n <= 2));
        chk({tag, ".overflow"}, 32'(bus.o_overflow), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(bus.o_underflow), 32'(m_unf));
        chk({tag, ".error"}, 32'(bus.o_error), 32'(m_err));
`ifdef QUEUE_STATS_EN
        chk({tag, ".peak"}, 32'(bus.o_peak_count), 32'(m_peak));
`endif
    endtask

    task automatic step(input string tag, input bit clr, mode, enq, deq, input logic [7:0] din);
        bus.i_clear = clr; bus.i_mode = mode; bus.i_enque = enq; bus.i_deque = deq; bus.i_data_in = din;
        @(posedge clk);
        #1;
        model(clr, mode, enq, deq, din);
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        bus.i_clear = 0; bus.i_mode = 0; bus.i_enque = 0; bus.i_deque = 0; bus.i_data_in = 0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1;

        // FIFO order, LIFO order with ignored mode pulse, underflow, clear priority
        tv.push_back(vec_t'{0,0,1,0,8'h11, 0,8'h00,1,0});
        tv.push_back(vec_t'{0,0,1,0,8'h22, 0,8'h00,2,0});
        tv.push_back(vec_t'{0,0,1,0,8'h33, 0,8'h00,3,0});
        tv.push_back(vec_t'{0,0,0,1,8'h00, 1,8'h11,2,0});
        tv.push_back(vec_t'{0,0,0,1,8'h00, 1,8'h22,1,0});
        tv.push_back(vec_t'{0,0,0,1,8'h00, 1,8'h33,0,0});
        tv.push_back(vec_t'{0,1,1,0,8'hA0, 0,8'h33,1,0});
        tv.push_back(vec_t'{0,0,1,0,8'hA1, 0,8'h33,2,0});
        tv.push_back(vec_t'{0,1,1,0,8'hA2, 0,8'h33,3,0});
        tv.push_back(vec_t'{0,0,0,1,8'h00, 1,8'hA2,2,0});
        tv.push_back(vec_t'{0,0,0,1,8'h00, 1,8'hA1,1,0});
        tv.push_back(vec_t'{0,0,0,1,8'h00, 1,8'hA0,0,0});
        tv.push_back(vec_t'{0,0,0,1,8'h00, 0,8'hA0,0,1});
        tv.push_back(vec_t'{0,0,0,0,8'h00, 0,8'hA0,0,0});
        tv.push_back(vec_t'{0,0,1,1,8'h5C, 0,8'hA0,1,1});
        tv.push_back(vec_t'{0,0,0,1,8'h00, 1,8'h5C,0,0});
        tv.push_back(vec_t'{0,0,1,0,8'h44, 0,8'h5C,1,0});
        tv.push_back(vec_t'{1,0,1,1,8'h55, 0,8'h5C,0,0});
        tv.push_back(vec_t'{0,0,0,0,8'h00, 0,8'h5C,0,0});
        foreach (tv[i]) begin
            step($sformatf("tv%0d", i), tv[i].clr, tv[i].mode, tv[i].enq, tv[i].deq, tv[i].din);
            chk($sformatf("tv%0d.exp_valid", i), 32'(bus.o_data_valid), 32'(tv[i].v));
            chk($sformatf("tv%0d.exp_dout", i), 32'(bus.o_data_out), 32'(tv[i].dout));
            chk($sformatf("tv%0d.exp_count", i), 32'(bus.o_count), 32'(tv[i].cnt));
            chk($sformatf("tv%0d.exp_error", i), 32'(bus.o_error), 32'(tv[i].err));
        end

        // Full, overflow and drain of the original 16 values
        step("ovf_clr", 1, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step("fill", 0, 0, 1, 0, 8'(i * 7 + 3));
        step("ovf", 0, 0, 1, 0, 8'hEE);
        chk("ovf.count16", 32'(bus.o_count), 32'd16);
        chk("ovf.flag", 32'(bus.o_overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 0, 0, 0, 1, 0);
            chk("drain.data", 32'(bus.o_data_out), 32'(8'(i * 7 + 3)));
        end

        // FIFO full with simultaneous enqueue and dequeue
        for (int i = 0; i < DEPTH; i++) step("fill2", 0, 0, 1, 0, 8'(i + 8'h40));
        step("fullboth", 0, 0, 1, 1, 8'h77);
        chk("fullboth.head", 32'(bus.o_data_out), 32'h40);
        chk("fullboth.count", 32'(bus.o_count), 32'd16);
        for (int i = 0; i < DEPTH; i++) step("drain2", 0, 0, 0, 1, 0);
        chk("drain2.last", 32'(bus.o_data_out), 32'h77);

        // LIFO replace-top
        step("lifo_mode", 0, 1, 0, 0, 0);
        step("lifo_p10", 0, 1, 1, 0, 8'h10);
        step("lifo_p20", 0, 1, 1, 0, 8'h20);
        step("lifo_rep", 0, 1, 1, 1, 8'h99);
        chk("lifo_rep.old_top", 32'(bus.o_data_out), 32'h20);
        step("lifo_pop1", 0, 1, 0, 1, 0);
        chk("lifo_pop1.data", 32'(bus.o_data_out), 32'h99);
        step("lifo_pop2", 0, 1, 0, 1, 0);
        chk("lifo_pop2.data", 32'(bus.o_data_out), 32'h10);

        // Pointer wrap: hold occupancy at 8 while both pointers advance 40 times
        step("wrap_mode", 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step("wrap_fill", 0, 0, 1, 0, 8'($urandom));
        for (int i = 0; i < 40; i++) step("wrap", 0, 0, 1, 1, 8'($urandom));

        // Clear with Count=5
        step("clr5_clr", 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("clr5_fill", 0, 0, 1, 0, 8'(i));
        step("clr5", 1, 0, 0, 0, 0);
        chk("clr5.count", 32'(bus.o_count), 32'd0);
`ifdef QUEUE_STATS_EN
        chk("clr5.peak", 32'(bus.o_peak_count), 32'd0);
`endif

        // Random traffic with phases biased toward filling and draining
        for (int i = 0; i < 1500; i++) begin
            bit fill_bias;
            fill_bias = ((i / 100) % 2) == 0;
            step("rand", $urandom_range(0, 63) == 0, 1'($urandom),
                 fill_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 1'($urandom), 8'($urandom));
        end

        // Asynchronous reset between edges during an enqueue burst
        for (int i = 0; i < 3; i++) step("burst", 0, 0, 1, 0, 8'(8'hC0 + i));
        bus.i_enque = 1; bus.i_data_in = 8'hCF;
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        model_reset();
        compare_all("async_rst");
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        step("post_rst_deq", 0, 0, 0, 1, 0);
        step("post_rst_enq", 0, 0, 1, 0, 8'h3A);
        step("post_rst_read", 0, 0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
